// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one result bit per cycle, with an optional
// one-cycle path for divide-by-zero and signed-overflow divides.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | shift-add multiply or restoring divide, counter 0..XLEN-1
// FIX   | sign correction and result selection
// DONE  | result presented, waiting for out_ready
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FASTPATH = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          op;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     b_abs, quo, res_q;
    logic [XLEN:0]       rem;
    logic [2*XLEN-1:0]   prod;
    logic                neg_q, neg_r;

    logic                accept, sa_in, sb_in, b_zero_in, ovf_in, special_in;
    logic [XLEN-1:0]     a_abs_in, b_abs_in, special_res;
    logic [XLEN:0]       mul_sum;
    logic [XLEN+1:0]     rem_sh;
    logic                rem_ge;
    logic [2*XLEN-1:0]   prod_f;
    logic [XLEN-1:0]     quo_f, rem_f, fix_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;

    assign accept = in_valid && in_ready && !kill;

    always_comb begin
        sa_in       = 1'b0;
        sb_in       = 1'b0;
        special_res = '0;
        case (funct3)
            3'd1, 3'd4, 3'd6: begin
                sa_in = rs1[XLEN-1];
                sb_in = rs2[XLEN-1];
            end
            3'd2:    sa_in = rs1[XLEN-1];
            default: ;
        endcase
        a_abs_in   = sa_in ? -rs1 : rs1;
        b_abs_in   = sb_in ? -rs2 : rs2;
        b_zero_in  = (rs2 == '0);
        ovf_in     = (funct3 == 3'd4 || funct3 == 3'd6) && (rs1 == MIN_NEG) && (rs2 == '1);
        special_in = funct3[2] && (b_zero_in || ovf_in);
        if (b_zero_in)
            special_res = funct3[1] ? rs1 : '1;
        else
            special_res = funct3[1] ? '0 : MIN_NEG;
    end

    // Datapath steps; rem_sh carries the full remainder so no bit is dropped before compare.
    always_comb begin
        mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? b_abs : {XLEN{1'b0}})};
        rem_sh  = {rem, quo[XLEN-1]};
        rem_ge  = (rem_sh >= {2'b00, b_abs});
        prod_f  = neg_q ? -prod : prod;
        quo_f   = neg_q ? -quo : quo;
        rem_f   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        case (op)
            3'd0:             fix_res = prod_f[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_f[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = quo_f;
            default:          fix_res = rem_f;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (FASTPATH && special_in) ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op    <= '0;
            cnt   <= '0;
            b_abs <= '0;
            quo   <= '0;
            rem   <= '0;
            prod  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res_q <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: if (accept) begin
                    op    <= funct3;
                    cnt   <= '0;
                    b_abs <= b_abs_in;
                    // A zero divisor keeps the all-ones quotient unsigned-looking.
                    neg_q <= (sa_in ^ sb_in) && !(funct3[2] && b_zero_in);
                    neg_r <= sa_in;
                    prod  <= {{XLEN{1'b0}}, a_abs_in};
                    quo   <= a_abs_in;
                    rem   <= '0;
                    if (FASTPATH && special_in) res_q <= special_res;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        quo <= {quo[XLEN-2:0], rem_ge};
                        rem <= rem_ge ? (XLEN+1)'(rem_sh - {2'b00, b_abs})
                                      : (XLEN+1)'(rem_sh);
                    end else begin
                        prod <= {mul_sum, prod[XLEN-1:1]};
                    end
                end
                FIX:     res_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: fast-path and full-latency 32-bit instances plus a
// 64-bit instance, checked against hand-computed results and latencies.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        kill = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  funct3 = '0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic [2:0]  iv = '0;
    logic [2:0]  ir, ov, bz;
    logic [31:0] res0, res1;
    logic [63:0] res2;

    int vecs = 0;
    int errs = 0;
    int sel  = 0;

    logic        cur_ir, cur_ov, cur_busy;
    logic [63:0] cur_res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .FASTPATH(1'b1)) u_fast32 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .funct3(funct3),
        .rs1(rs1[31:0]), .rs2(rs2[31:0]), .kill(kill), .out_valid(ov[0]),
        .out_ready(out_ready), .result(res0), .busy(bz[0]));

    muldiv_unit #(.XLEN(32), .FASTPATH(1'b0)) u_slow32 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .funct3(funct3),
        .rs1(rs1[31:0]), .rs2(rs2[31:0]), .kill(kill), .out_valid(ov[1]),
        .out_ready(out_ready), .result(res1), .busy(bz[1]));

    muldiv_unit #(.XLEN(64), .FASTPATH(1'b1)) u_x64 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(ov[2]),
        .out_ready(out_ready), .result(res2), .busy(bz[2]));

    always_comb begin
        cur_ir   = ir[0];
        cur_ov   = ov[0];
        cur_busy = bz[0];
        cur_res  = {32'b0, res0};
        case (sel)
            1: begin
                cur_ir = ir[1]; cur_ov = ov[1]; cur_busy = bz[1]; cur_res = {32'b0, res1};
            end
            2: begin
                cur_ir = ir[2]; cur_ov = ov[2]; cur_busy = bz[2]; cur_res = res2;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one op on the selected instance; latency counts cycles after the accept edge.
    task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv = '0;
        lat = 1;
        busy_ok = 1'b1;
        while (!cur_ov && lat < 200) begin
            if (!cur_busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = cur_res;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_vec(input string tag, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int elat);
        logic [63:0] res;
        int          lat;
        bit          bok;
        run_op(f, a, b, res, lat, bok);
        chk(tag, res, exp);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        logic [63:0] res, prev;
        int          lat;
        bit          bok, flag_a, flag_b;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'b0, cur_ir}, 64'd1);
        chk("rst_out_valid", {63'b0, cur_ov}, 64'd0);
        chk("rst_busy", {63'b0, cur_busy}, 64'd0);
        chk("rst_result", cur_res, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        sel = 0;
        run_op(MUL, 64'd7, 64'hFFFFFFFD, res, lat, bok);
        chk("mul", res, 64'hFFFFFFEB);
        chk("mul_lat", 64'(lat), 64'd34);
        chk("mul_busy", {63'b0, bok}, 64'd1);
        do_vec("mulh",   MULH,   64'h80000000, 64'h80000000, 64'h40000000, 34);
        do_vec("mulhsu", MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 34);
        do_vec("mulhu",  MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34);
        do_vec("div",    DIV,    64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34);
        do_vec("rem",    REM,    64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 34);
        do_vec("divu",   DIVU,   64'd100, 64'd7, 64'd14, 34);
        do_vec("remu",   REMU,   64'd100, 64'd7, 64'd2, 34);
        do_vec("f_divu0", DIVU, 64'h1234, 64'd0, 64'hFFFFFFFF, 1);
        do_vec("f_rem0",  REM,  64'h1234, 64'd0, 64'h1234, 1);
        do_vec("f_dovf",  DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
        do_vec("f_rovf",  REM,  64'h80000000, 64'hFFFFFFFF, 64'd0, 1);

        sel = 1;
        do_vec("s_divu0", DIVU, 64'h1234, 64'd0, 64'hFFFFFFFF, 34);
        do_vec("s_rem0",  REM,  64'h1234, 64'd0, 64'h1234, 34);
        do_vec("s_dovf",  DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 34);
        do_vec("s_rovf",  REM,  64'h80000000, 64'hFFFFFFFF, 64'd0, 34);
        do_vec("s_div0_neg", DIV, 64'hFFFFFFF9, 64'd0, 64'hFFFFFFFF, 34);

        // Held result with a second request waiting on in_valid.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(MUL, 64'd3, 64'd5, res, lat, bok);
        chk("hs_first", res, 64'd15);
        @(negedge clk);
        funct3 = DIVU; rs1 = 64'd100; rs2 = 64'd7; iv[1] = 1'b1;
        flag_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (cur_res !== 64'd15 || cur_ir !== 1'b0 || cur_ov !== 1'b1) flag_a = 1'b0;
        end
        chk("hs_hold", {63'b0, flag_a}, 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_release_ready", {63'b0, cur_ir}, 64'd1);
        chk("hs_release_valid", {63'b0, cur_ov}, 64'd0);
        @(posedge clk); #1;
        chk("hs_second_accept", {63'b0, cur_busy}, 64'd1);
        iv = '0;
        lat = 1;
        while (!cur_ov && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hs_second", cur_res, 64'd14);
        chk("hs_second_lat", 64'(lat), 64'd34);
        @(posedge clk); #1;

        // Kill during CALC at counter 10.
        prev = cur_res;
        @(negedge clk);
        funct3 = MUL; rs1 = 64'd7; rs2 = 64'd3; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", {63'b0, cur_ir}, 64'd1);
        chk("kill_busy", {63'b0, cur_busy}, 64'd0);
        chk("kill_result", cur_res, prev);
        flag_b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (cur_ov) flag_b = 1'b0;
        end
        chk("kill_no_valid", {63'b0, flag_b}, 64'd1);

        // Reset in the middle of CALC.
        @(negedge clk);
        funct3 = DIVU; rs1 = 64'd100; rs2 = 64'd7; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_ready", {63'b0, cur_ir}, 64'd1);
        chk("mrst_valid", {63'b0, cur_ov}, 64'd0);
        chk("mrst_busy", {63'b0, cur_busy}, 64'd0);
        chk("mrst_result", cur_res, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        sel = 2;
        do_vec("x64_mulhu", MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 66);
        do_vec("x64_mul",   MUL,   64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 66);
        do_vec("x64_divu",  DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 66);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
